// File: rtl/hazard_scoreboard_if.sv
// Issue/retire/read-port bundle between the ID/WB pipeline control and the
// pending-write scoreboard.
interface hazard_scoreboard_if #(
  parameter int NumRegs = 15
);
  logic [3:0]         src1;
  logic [3:0]         src2;
  logic               useSrc1;
  logic               useSrc2;
  logic               readsFlags;
  logic               issueValid;
  logic [3:0]         issueDest;
  logic               issueWbEn;
  logic               issueSetsFlags;
  logic               retireEn;
  logic [3:0]         retireDest;
  logic               flagsUpdate;
  logic               stall;
  logic [NumRegs-1:0] pendingMask;
  logic               flagsPending;
  logic               err;

  modport master (
    output src1, src2, useSrc1, useSrc2, readsFlags,
    output issueValid, issueDest, issueWbEn, issueSetsFlags,
    output retireEn, retireDest, flagsUpdate,
    input  stall, pendingMask, flagsPending, err
  );

  modport slave (
    input  src1, src2, useSrc1, useSrc2, readsFlags,
    input  issueValid, issueDest, issueWbEn, issueSetsFlags,
    input  retireEn, retireDest, flagsUpdate,
    output stall, pendingMask, flagsPending, err
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Pending-write scoreboard: per-register and flag in-flight write counters
// with a combinational RAW stall that bypasses same-cycle retires.
module hazard_scoreboard #(
  parameter int NumRegs  = 15,
  parameter int CntWidth = 2
) (
  input logic           clk,
  input logic           rst,
  hazard_scoreboard_if.slave sb
);
  localparam logic [CntWidth-1:0] CntMax = '1;
  localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

  logic [CntWidth-1:0] cnt     [NumRegs];
  logic [CntWidth-1:0] cnt_nxt [NumRegs];
  logic [CntWidth-1:0] flag_cnt;
  logic [CntWidth-1:0] flag_cnt_nxt;
  logic                err_q;
  logic                err_nxt;
  logic [NumRegs-1:0]  inc;
  logic [NumRegs-1:0]  dec;
  logic [15:0]         pend_eff;
  logic                flag_pend_eff;
  logic                stall;
  logic                iss;

  // Returns {error, next}; the counter holds on overflow/underflow.
  function automatic logic [CntWidth:0] sat_step(
    input logic [CntWidth-1:0] c,
    input logic                up,
    input logic                down
  );
    logic [CntWidth:0] r;
    r = {1'b0, c};
    if (up && !down) begin
      if (c == CntMax) r[CntWidth] = 1'b1;
      else             r = {1'b0, c + CntOne};
    end else if (down && !up) begin
      if (c == '0) r[CntWidth] = 1'b1;
      else         r = {1'b0, c - CntOne};
    end
    return r;
  endfunction

  // Index 15 (PC) has no counter, so its pend_eff bit stays 0.
  always_comb begin
    dec      = '0;
    pend_eff = '0;
    for (int i = 0; i < NumRegs; i++) begin
      dec[i]      = sb.retireEn && (sb.retireDest == 4'(i));
      pend_eff[i] = (cnt[i] != '0) && !(dec[i] && (cnt[i] == CntOne));
    end
  end

  assign flag_pend_eff = (flag_cnt != '0) && !(sb.flagsUpdate && (flag_cnt == CntOne));

  assign stall = (sb.useSrc1 && pend_eff[sb.src1]) ||
                 (sb.useSrc2 && pend_eff[sb.src2]) ||
                 (sb.readsFlags && flag_pend_eff);

  assign iss = sb.issueValid && !stall;

  always_comb begin
    logic [CntWidth:0] step;
    inc     = '0;
    err_nxt = err_q;
    for (int i = 0; i < NumRegs; i++) begin
      inc[i]     = iss && sb.issueWbEn && (sb.issueDest == 4'(i));
      step       = sat_step(cnt[i], inc[i], dec[i]);
      cnt_nxt[i] = step[CntWidth-1:0];
      err_nxt    = err_nxt | step[CntWidth];
    end
    step         = sat_step(flag_cnt, iss && sb.issueSetsFlags, sb.flagsUpdate);
    flag_cnt_nxt = step[CntWidth-1:0];
    err_nxt      = err_nxt | step[CntWidth];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NumRegs; i++) cnt[i] <= '0;
      flag_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      for (int i = 0; i < NumRegs; i++) cnt[i] <= cnt_nxt[i];
      flag_cnt <= flag_cnt_nxt;
      err_q    <= err_nxt;
    end
  end

  always_comb begin
    sb.pendingMask = '0;
    for (int i = 0; i < NumRegs; i++) sb.pendingMask[i] = (cnt[i] != '0);
  end

  assign sb.flagsPending = (flag_cnt != '0);
  assign sb.err          = err_q;
  assign sb.stall        = stall;
endmodule
